// File: rtl/mips_pkg.sv
// mips_pkg: shared types and default sizes for the MEM stage.
package mips_pkg;
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    localparam int SIZE_VAL    = 32;
    localparam int SIZE_AD     = 5;
    localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/dm_access_fsm.sv
// dm_access_fsm: IDLE/REQ/DONE sequencing of data-memory accesses.
// With MEM_TIMEOUT_EN defined, REQ gives up after TIMEOUT cycles and sets a sticky error.
module dm_access_fsm
    import mips_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   mem_op_i,
    input  logic   ack_i,
    output state_t state_o,
    output logic   kill_o,
    output logic   err_o
);
    state_t state_q, state_d;
    logic   tmo;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          kill_q, kill_d, err_q, err_d;
    assign tmo = (state_q == REQ) && !ack_i && (cnt_q == CW'(TIMEOUT - 1));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            kill_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            kill_q <= kill_d;
            err_q  <= err_d;
        end
    end
    always_comb begin
        cnt_d  = (state_q == REQ) ? cnt_q + 1'b1 : '0;
        kill_d = tmo;
        err_d  = err_q | tmo;
    end
    assign kill_o = kill_q;
    assign err_o  = err_q;
`else
    assign tmo    = 1'b0;
    assign kill_o = 1'b0;
    assign err_o  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // DONE behaves like IDLE: the stage is free and captures the next instruction
    always_comb begin
        state_d = (state_q == REQ) ? ((ack_i || tmo) ? DONE : REQ)
                                   : (mem_op_i ? REQ : IDLE);
    end

    always_comb begin
        state_o = state_q;
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: EX/MEM register and data-memory access with pipeline stall.
// Define MEM_TIMEOUT_EN to enable the ack timeout and sticky MemErr.
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int sizeVal = SIZE_VAL,
    parameter int sizeAd  = SIZE_AD,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               RFWEE,
    input  logic               MtoRFSelE,
    input  logic               DMWEE,
    input  logic [sizeVal-1:0] ALUOutE,
    input  logic [sizeVal-1:0] DMinE,
    input  logic [sizeAd-1:0]  RFAE,
    output logic               RFWEM,
    output logic               MtoRFSelM,
    output logic [sizeVal-1:0] ALUOutM,
    output logic [sizeVal-1:0] DMOutM,
    output logic [sizeAd-1:0]  RFAM,
    output logic               dm_req,
    output logic               dm_we,
    output logic [sizeVal-1:0] dm_addr,
    output logic [sizeVal-1:0] dm_wdata,
    input  logic [sizeVal-1:0] dm_rdata,
    input  logic               dm_ack,
    output logic               StallM,
    output logic               MemErr
);
    typedef struct packed {
        logic               rfwe;
        logic               mtorf;
        logic               dmwe;
        logic [sizeVal-1:0] alu;
        logic [sizeVal-1:0] din;
        logic [sizeAd-1:0]  rfa;
    } ex_t;

    ex_t                ex_q, ex_d;
    logic [sizeVal-1:0] rdata_q, rdata_d;
    state_t             state;
    logic               stall, kill, live, is_load;

    dm_access_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
        .clk     (clk),
        .rst     (rst),
        .mem_op_i(MtoRFSelE | DMWEE),
        .ack_i   (dm_ack),
        .state_o (state),
        .kill_o  (kill),
        .err_o   (MemErr)
    );

    assign stall   = (state == REQ);
    assign live    = !stall;
    assign is_load = ex_q.mtorf && !ex_q.dmwe;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q    <= '0;
            rdata_q <= '0;
        end else begin
            ex_q    <= ex_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        ex_d    = stall ? ex_q : '{RFWEE, MtoRFSelE, DMWEE, ALUOutE, DMinE, RFAE};
        rdata_d = (stall && dm_ack) ? dm_rdata : rdata_q;
    end

    // REQ presents a bubble downstream while driving the memory port
    always_comb begin
        RFWEM     = live && ex_q.rfwe && !kill;
        MtoRFSelM = live && ex_q.mtorf;
        ALUOutM   = live ? ex_q.alu : '0;
        DMOutM    = (live && is_load && !kill) ? rdata_q : '0;
        RFAM      = live ? ex_q.rfa : '0;
        dm_req    = stall;
        dm_we     = stall && ex_q.dmwe;
        dm_addr   = stall ? ex_q.alu : '0;
        dm_wdata  = stall ? ex_q.din : '0;
        StallM    = stall;
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed stimulus checked every cycle against a transaction-level model.
module tb_mem_access_stage;
    logic        clk, rst;
    logic        RFWEE, MtoRFSelE, DMWEE;
    logic [31:0] ALUOutE, DMinE;
    logic [4:0]  RFAE;
    logic        RFWEM, MtoRFSelM;
    logic [31:0] ALUOutM, DMOutM;
    logic [4:0]  RFAM;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_ack, StallM, MemErr;

    mem_access_stage dut (
        .clk(clk), .rst(rst),
        .RFWEE(RFWEE), .MtoRFSelE(MtoRFSelE), .DMWEE(DMWEE),
        .ALUOutE(ALUOutE), .DMinE(DMinE), .RFAE(RFAE),
        .RFWEM(RFWEM), .MtoRFSelM(MtoRFSelM), .ALUOutM(ALUOutM),
        .DMOutM(DMOutM), .RFAM(RFAM),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .StallM(StallM), .MemErr(MemErr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rfwe, mtorf, dmwe;
        logic [31:0] alu, din;
        logic [4:0]  rfa;
    } ins_t;

    ins_t        cur;
    logic        pend, kill, merr;
    logic [31:0] mrdata;
    int          wcnt;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic model_clear();
        cur    = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0};
        pend   = 1'b0;
        kill   = 1'b0;
        merr   = 1'b0;
        mrdata = 32'h0;
        wcnt   = 0;
    endtask

    // An instruction either waits on memory (pend) or is visible downstream
    task automatic model_edge();
        if (!rst) model_clear();
        else if (pend) begin
            if (dm_ack) begin
                pend = 1'b0;
                if (cur.mtorf && !cur.dmwe) mrdata = dm_rdata;
            end
`ifdef MEM_TIMEOUT_EN
            else begin
                wcnt++;
                if (wcnt == 16) begin
                    pend = 1'b0;
                    kill = 1'b1;
                    merr = 1'b1;
                end
            end
`endif
        end else begin
            cur  = '{RFWEE, MtoRFSelE, DMWEE, ALUOutE, DMinE, RFAE};
            pend = MtoRFSelE | DMWEE;
            kill = 1'b0;
            wcnt = 0;
        end
    endtask

    task automatic check_all();
        chk("StallM", 32'(StallM), 32'(pend));
        chk("dm_req", 32'(dm_req), 32'(pend));
        chk("dm_we", 32'(dm_we), 32'(pend && cur.dmwe));
        chk("dm_addr", dm_addr, pend ? cur.alu : 32'h0);
        chk("dm_wdata", dm_wdata, pend ? cur.din : 32'h0);
        chk("RFWEM", 32'(RFWEM), 32'(!pend && cur.rfwe && !kill));
        chk("MtoRFSelM", 32'(MtoRFSelM), 32'(!pend && cur.mtorf));
        chk("ALUOutM", ALUOutM, pend ? 32'h0 : cur.alu);
        chk("RFAM", 32'(RFAM), pend ? 32'h0 : 32'(cur.rfa));
        chk("DMOutM", DMOutM, (!pend && cur.mtorf && !cur.dmwe && !kill) ? mrdata : 32'h0);
        chk("MemErr", 32'(MemErr), 32'(merr));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic set_e(input logic w, input logic m, input logic s,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
        RFWEE = w; MtoRFSelE = m; DMWEE = s; ALUOutE = a; DMinE = d; RFAE = r;
    endtask

    task automatic ack(input logic k, input logic [31:0] d);
        dm_ack = k; dm_rdata = d;
    endtask

    initial begin
        rst = 1'b0;
        set_e(0, 0, 0, 0, 0, 0);
        ack(0, 0);
        model_clear();
        #2;
        check_all();
        chk("reset_alu", ALUOutM, 32'h0);
        step();
        rst = 1'b1;
        step();

        // ALU op
        set_e(1, 0, 0, 32'h10, 0, 3);
        step();
        chk("alu_rfwe", 32'(RFWEM), 32'd1);
        chk("alu_out", ALUOutM, 32'h10);
        chk("alu_rfa", 32'(RFAM), 32'd3);
        chk("alu_stall", 32'(StallM), 32'd0);

        // load, ack in first REQ cycle
        set_e(1, 1, 0, 32'h40, 0, 5);
        step();
        chk("ld_stall", 32'(StallM), 32'd1);
        chk("ld_addr", dm_addr, 32'h40);
        chk("ld_bubble", 32'(RFWEM), 32'd0);
        set_e(0, 0, 0, 0, 0, 0);
        ack(1, 32'hDEADBEEF);
        step();
        chk("ld_data", DMOutM, 32'hDEADBEEF);
        chk("ld_mtorf", 32'(MtoRFSelM), 32'd1);
        chk("ld_rfwe", 32'(RFWEM), 32'd1);
        ack(0, 0);
        step();

        // store, ack after 3 waiting cycles
        set_e(0, 0, 1, 32'h80, 32'h12345678, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            set_e(0, 0, 0, 0, 0, 0);
            chk("st_wdata", dm_wdata, 32'h12345678);
            chk("st_we", 32'(dm_we), 32'd1);
            step();
        end
        chk("st_stall4", 32'(StallM), 32'd1);
        ack(1, 32'h55AA55AA);
        step();
        chk("st_rfwe", 32'(RFWEM), 32'd0);
        chk("st_dmout", DMOutM, 32'h0);
        ack(0, 0);
        step();

        // back-to-back loads
        set_e(1, 1, 0, 32'h4, 0, 1);
        step();
        set_e(1, 1, 0, 32'h8, 0, 2);
        ack(1, 32'h11111111);
        step();
        chk("b2b_d1", DMOutM, 32'h11111111);
        chk("b2b_req_done", 32'(dm_req), 32'd0);
        ack(0, 0);
        step();
        chk("b2b_addr2", dm_addr, 32'h8);
        set_e(0, 0, 0, 0, 0, 0);
        ack(1, 32'h22222222);
        step();
        chk("b2b_d2", DMOutM, 32'h22222222);
        chk("b2b_rfa2", 32'(RFAM), 32'd2);
        ack(0, 0);
        step();

        // load+store flags together behave as a store
        set_e(0, 1, 1, 32'h100, 32'hCAFE, 0);
        ack(1, 32'h99999999);
        step();
        chk("ls_we", 32'(dm_we), 32'd1);
        set_e(0, 0, 0, 0, 0, 0);
        step();
        chk("ls_dmout", DMOutM, 32'h0);
        ack(0, 0);
        step();

        // ack outside REQ is ignored
        ack(1, 32'h77777777);
        step();
        ack(0, 0);

        // reset in the middle of REQ
        set_e(1, 1, 0, 32'h200, 0, 7);
        step();
        set_e(0, 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk("rst_req", 32'(dm_req), 32'd0);
        chk("rst_stall", 32'(StallM), 32'd0);
        chk("rst_alu", ALUOutM, 32'h0);
        model_clear();
        check_all();
        step();
        rst = 1'b1;
        ack(1, 32'h00000BAD);
        step();
        chk("rst_late_ack", 32'(StallM), 32'd0);
        chk("rst_late_data", DMOutM, 32'h0);
        ack(0, 0);
        step();

        // no ack for a long time
        set_e(1, 1, 0, 32'h300, 0, 9);
        step();
        set_e(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step();
`ifdef MEM_TIMEOUT_EN
        chk("to_err", 32'(MemErr), 32'd1);
        chk("to_stall", 32'(StallM), 32'd0);
        step();
        chk("to_sticky", 32'(MemErr), 32'd1);
`else
        chk("noto_stall", 32'(StallM), 32'd1);
        chk("noto_err", 32'(MemErr), 32'd0);
        ack(1, 32'h0BADF00D);
        step();
        chk("noto_data", DMOutM, 32'h0BADF00D);
        ack(0, 0);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameters SHALL be: sizeVal, default 32, data/address width; sizeAd, default 5, register-file address width; TIMEOUT, default 16, ack wait limit in cycles.
REQ-002 Ports SHALL be, in order: clk in 1 clock; rst in 1 reset, asynchronous, active-low.
REQ-003 Ports from EX: RFWEE in 1 reg write enable; MtoRFSelE in 1 load select; DMWEE in 1 store enable; ALUOutE in sizeVal address/result; DMinE in sizeVal store data; RFAE in sizeAd destination register.
REQ-004 Ports to MEM/WB register: RFWEM out 1; MtoRFSelM out 1; ALUOutM out sizeVal; DMOutM out sizeVal load data; RFAM out sizeAd.
REQ-005 Data memory port: dm_req out 1; dm_we out 1; dm_addr out sizeVal; dm_wdata out sizeVal; dm_rdata in sizeVal; dm_ack in 1.
REQ-006 Control/status: StallM out 1, freezes the IF/ID/EX stages; MemErr out 1, sticky timeout error.

Function
REQ-007 The block SHALL hold an internal EX/MEM register (RFWE, MtoRFSel, DMWE, ALUOut, DMin, RFA) loaded from the E inputs on every clk edge where StallM=0.
REQ-008 A captured instruction SHALL be a memory op when MtoRFSel=1 or DMWE=1; MtoRFSel=1 and DMWE=1 together SHALL be treated as a store.
REQ-009 FSM states SHALL be IDLE, REQ and DONE.
REQ-010 IDLE: if a memory op is captured, next state is REQ; otherwise stay IDLE.
REQ-011 REQ: dm_req=1; dm_we=DMWE; dm_addr=ALUOut; dm_wdata=DMin; on dm_ack=1, next state is DONE and dm_rdata is latched for loads.
REQ-012 DONE lasts exactly one cycle with StallM=0; if the instruction captured at its end is a memory op, next state is REQ, otherwise IDLE.
REQ-013 StallM SHALL be 1 exactly when state=REQ; it is decoded from registered state only, with no combinational path from dm_ack.
REQ-014 Outputs in IDLE and DONE SHALL be the internal register values, with DMOutM = latched read data for loads and 0 for stores and non-memory ops.
REQ-015 Outputs in REQ SHALL be a bubble: RFWEM=0, MtoRFSelM=0, RFAM=0, ALUOutM=0, DMOutM=0.
REQ-016 Latency: a non-memory op appears on the outputs 1 cycle after capture; a memory op with same-cycle ack appears 2 cycles after capture; each further cycle without ack adds 1 cycle.
REQ-017 dm_ack outside REQ SHALL be ignored; dm_rdata SHALL be sampled only in REQ when dm_ack=1.
REQ-018 Addresses SHALL pass through unmodified at full sizeVal width, with no alignment checking.

Reset
REQ-019 rst=0 SHALL asynchronously force state to IDLE, clear all internal registers, and hold all outputs at 0, including dm_req, StallM and MemErr.
REQ-020 Reset asserted during REQ SHALL drop dm_req immediately and discard the pending access; no late ack may be latched after release.

Configuration
REQ-021 When MEM_TIMEOUT_EN is defined, a counter SHALL run in REQ; after TIMEOUT consecutive cycles without ack, dm_req drops, the FSM enters DONE with RFWEM forced to 0, and MemErr is set until reset.
REQ-022 When MEM_TIMEOUT_EN is not defined, REQ SHALL wait indefinitely, MemErr SHALL be tied to 0, and no counter logic SHALL exist.

Structure
REQ-023 Package mips_pkg SHALL hold the FSM state typedef (IDLE/REQ/DONE), the default sizeVal/sizeAd values, and the TIMEOUT default constant.
REQ-024 The FSM and timeout counter SHALL live in one sub-module, dm_access_fsm; the register and datapath stay in the top module.

Verification
REQ-025 ALU op (RFWEE=1, ALUOutE=0x00000010, RFAE=3) -> next cycle RFWEM=1, ALUOutM=0x10, RFAM=3, DMOutM=0, StallM=0, dm_req=0.
REQ-026 Load addr 0x40, ack with dm_rdata=0xDEADBEEF in the first REQ cycle -> one bubble cycle with StallM=1, then DMOutM=0xDEADBEEF, MtoRFSelM=1, RFWEM=1.
REQ-027 Store addr 0x80, data 0x12345678, ack delayed 3 cycles -> dm_we=1, dm_wdata=0x12345678 held for 4 cycles with StallM=1, then RFWEM=0, DMOutM=0.
REQ-028 Back-to-back loads 0x4 then 0x8 -> two REQ phases separated by one DONE cycle; the second address is captured at the end of DONE.
REQ-029 rst pulsed low mid-REQ with ack arriving after release -> dm_req=0 immediately, outputs 0, ack ignored, FSM stays IDLE.
REQ-030 With MEM_TIMEOUT_EN and TIMEOUT=16, no ack -> dm_req drops after 16 cycles, MemErr=1 and sticky, RFWEM=0; without the macro, StallM stays 1.
